alu_issue: RTL

//  Initiator side of the ALU action/operand handshake. Accepts one action plus three container

---
 rtl/alu_issue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// ALU issue stage: takes one request (action + three operands + tenant id),
// presents it to the ALU together with the tenant's page-table entry, and
// buffers the single ALU result for the downstream result handshake.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no op in flight; accept a request when the ALU is ready
// S_ISSUE | action_valid pulse to the ALU (exactly one cycle)
// S_WAIT  | waiting for alu_result_valid; timeout counter runs here
module alu_issue #(
    parameter int ACTION_LEN  = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int VID_WIDTH   = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ACTION_LEN-1:0] req_action,
    input  logic [DATA_WIDTH-1:0] req_op1,
    input  logic [DATA_WIDTH-1:0] req_op2,
    input  logic [DATA_WIDTH-1:0] req_op3,
    input  logic [VID_WIDTH-1:0]  req_vid,
    input  logic                  cfg_we,
    input  logic [VID_WIDTH-1:0]  cfg_vid,
    input  logic [15:0]           cfg_entry,
    output logic [ACTION_LEN-1:0] action_out,
    output logic                  action_valid,
    output logic [DATA_WIDTH-1:0] operand_1_out,
    output logic [DATA_WIDTH-1:0] operand_2_out,
    output logic [DATA_WIDTH-1:0] operand_3_out,
    output logic [15:0]           page_tbl_out,
    output logic                  page_tbl_out_valid,
    input  logic                  alu_ready,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_result_valid,
    output logic                  alu_ready_in,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [VID_WIDTH-1:0]  res_vid,
    output logic [7:0]            res_opcode,
    output logic                  err_timeout
);

    localparam int CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int PT_DEPTH = 1 << VID_WIDTH;
    // The flag is raised on the same edge the counter reaches TIMEOUT_CYC.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   accept;
    logic                   capture;
    logic [15:0]            page_tbl [PT_DEPTH];
    logic [VID_WIDTH-1:0]   vid_q;
    logic [7:0]             opcode_q;
    logic [CNT_W-1:0]       to_cnt;

    // The ALU may only return a result when the output buffer can take it.
    assign alu_ready_in = ~res_valid | res_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        action_valid = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = alu_ready;
                accept    = req_valid & alu_ready;
                if (accept) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                action_valid = 1'b1;
                state_next   = S_WAIT;
            end
            S_WAIT: begin
                capture = alu_result_valid;
                if (capture) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Per-tenant page table; a same-cycle lookup sees the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PT_DEPTH; i++) begin
                page_tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            page_tbl[cfg_vid] <= cfg_entry;
        end
    end

    // Request registers held stable to the ALU until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            action_out         <= '0;
            operand_1_out      <= '0;
            operand_2_out      <= '0;
            operand_3_out      <= '0;
            vid_q              <= '0;
            opcode_q           <= '0;
            page_tbl_out       <= '0;
            page_tbl_out_valid <= 1'b0;
        end else if (accept) begin
            action_out         <= req_action;
            operand_1_out      <= req_op1;
            operand_2_out      <= req_op2;
            operand_3_out      <= req_op3;
            vid_q              <= req_vid;
            opcode_q           <= req_action[ACTION_LEN-1 -: 8];
            page_tbl_out       <= page_tbl[req_vid];
            page_tbl_out_valid <= 1'b1;
        end else if (capture) begin
            page_tbl_out_valid <= 1'b0;
        end
    end

    // One-entry result buffer; a capture on the pop edge keeps it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_vid    <= '0;
            res_opcode <= '0;
        end else if (capture) begin
            res_valid  <= 1'b1;
            res_data   <= alu_result;
            res_vid    <= vid_q;
            res_opcode <= opcode_q;
        end else if (res_valid && res_ready) begin
            res_valid  <= 1'b0;
        end
    end

    // Watchdog on the ALU: counts only cycles where the ALU was allowed to answer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (state == S_ISSUE) begin
            to_cnt <= '0;
        end else if (state == S_WAIT && alu_ready_in && !alu_result_valid) begin
            if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
            if (to_cnt == TO_LAST) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule
